mem_dbus_req: RTL and testbench

MEM-stage data-bus request controller. Converts the MEM stage's load/store instruction into one handshaked request on the data-cache port, aligns store data, and generates byte strobes. It detects address-alignment exceptions, stalls MEM until the request is accepted and MEM2 can take the instruction, and tracks outstanding transactions. Read data is returned in MEM2. `mem2_data_ok` qualifies it and suppresses responses to flushed requests.

---
 rtl/mem_dbus_req.sv | 165 ++++++++++++++++
 tb/tb_mem_dbus_req.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dbus_req.sv
// MEM-stage data-bus request controller: issues one handshaked load/store request
// per memory instruction, aligns store data, and filters responses to flushed requests.
module mem_dbus_req #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [2:0]  mem_load_type,
  input  logic [1:0]  mem_store_type,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_store_data,
  input  logic        mem_flush,
  input  logic        mem2_allow_in,
  output logic        dbus_req,
  output logic        dbus_wr,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_wstrb,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_addr_ok,
  input  logic        dbus_data_ok,
  output logic        mem2_data_ok,
  output logic        mem_adel,
  output logic        mem_ades,
  output logic        mem_stall,
  output logic        mem_req_done
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, CANCEL} state_t;

  localparam logic [1:0] MAX_CNT = 2'(MAX_OUTSTANDING);

  state_t      state, state_nxt;
  logic [1:0]  out_cnt, disc_cnt;
  logic        is_load, is_store, is_op;
  logic        half_ld, word_ld, half_st, word_st;
  logic        op_go, accept, discard, disc_dec;
  logic [3:0]  wstrb_nxt;
  logic [31:0] wdata_nxt;

  // A load type wins when both a load and a store type are presented.
  assign is_load  = mem_valid && (mem_load_type inside {[3'd1:3'd5]});
  assign is_store = mem_valid && !is_load && (mem_store_type != 2'd0);
  assign is_op    = is_load || is_store;

  assign half_ld = is_load && (mem_load_type == 3'd3 || mem_load_type == 3'd4);
  assign word_ld = is_load && (mem_load_type == 3'd5);
  assign half_st = is_store && (mem_store_type == 2'd2);
  assign word_st = is_store && (mem_store_type == 2'd3);

  assign mem_adel = (half_ld && mem_addr[0]) || (word_ld && (mem_addr[1:0] != 2'b00));
  assign mem_ades = (half_st && mem_addr[0]) || (word_st && (mem_addr[1:0] != 2'b00));

  assign op_go  = is_op && !mem_adel && !mem_ades && !mem_flush &&
                  (state == IDLE) && (out_cnt < MAX_CNT);
  assign accept = dbus_req && dbus_addr_ok;

  // NOTE: every signal assigned in a combinational block gets a default first,
  // otherwise an unassigned path infers a latch.
  always_comb begin
    wstrb_nxt = 4'b0000;
    wdata_nxt = 32'b0;
    if (is_store) begin
      case (mem_store_type)
        2'd1: begin
          wstrb_nxt = 4'b0001 << mem_addr[1:0];
          wdata_nxt = {4{mem_store_data[7:0]}};
        end
        2'd2: begin
          wstrb_nxt = mem_addr[1] ? 4'b1100 : 4'b0011;
          wdata_nxt = {2{mem_store_data[15:0]}};
        end
        default: begin
          wstrb_nxt = 4'b1111;
          wdata_nxt = mem_store_data;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (op_go) state_nxt = REQ;
      REQ: begin
        if (dbus_addr_ok)   state_nxt = (mem_flush || mem2_allow_in) ? IDLE : HOLD;
        else if (mem_flush) state_nxt = CANCEL;
      end
      HOLD:    if (mem_flush || mem2_allow_in) state_nxt = IDLE;
      CANCEL:  if (dbus_addr_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A request is never withdrawn before addr_ok, so CANCEL keeps dbus_req high.
  always_comb begin
    dbus_req     = 1'b0;
    mem_req_done = 1'b0;
    discard      = 1'b0;
    case (state)
      REQ: begin
        dbus_req = 1'b1;
        if (dbus_addr_ok) begin
          if (mem_flush)          discard      = 1'b1;
          else if (mem2_allow_in) mem_req_done = 1'b1;
        end
      end
      HOLD: begin
        if (mem_flush)          discard      = 1'b1;
        else if (mem2_allow_in) mem_req_done = 1'b1;
      end
      CANCEL: begin
        dbus_req = 1'b1;
        discard  = dbus_addr_ok;
      end
      default: ;
    endcase
  end

  assign mem_stall = !mem_flush && !mem_adel && !mem_ades && is_op &&
                     !mem_req_done && (state != CANCEL);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dbus_wr    <= 1'b0;
      dbus_addr  <= 32'b0;
      dbus_wstrb <= 4'b0000;
      dbus_wdata <= 32'b0;
    end else if (op_go) begin
      dbus_wr    <= is_store;
      dbus_addr  <= mem_addr;
      dbus_wstrb <= wstrb_nxt;
      dbus_wdata <= wdata_nxt;
    end
  end

  // Discards are oldest-first in the response stream; a same-cycle data_ok
  // belongs to an older request, so the discard count is read before it grows.
  assign disc_dec     = dbus_data_ok && (disc_cnt != 2'd0);
  assign mem2_data_ok = dbus_data_ok && (disc_cnt == 2'd0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_cnt  <= 2'd0;
      disc_cnt <= 2'd0;
    end else begin
      case ({accept, dbus_data_ok})
        2'b10:   out_cnt <= out_cnt + 2'd1;
        2'b01:   out_cnt <= out_cnt - 2'd1;
        default: ;
      endcase
      disc_cnt <= disc_cnt + 2'(discard) - 2'(disc_dec);
    end
  end

  assert property (@(posedge clk) disable iff (!resetn) !(dbus_data_ok && out_cnt == 2'd0));

endmodule

// File: tb/tb_mem_dbus_req.sv
// Bench for mem_dbus_req: directed scenarios plus randomized pipeline traffic,
// every cycle compared against a transaction-level reference model.
module tb_mem_dbus_req;

  localparam int MAX_OUT = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_valid;
  logic [2:0]  mem_load_type;
  logic [1:0]  mem_store_type;
  logic [31:0] mem_addr;
  logic [31:0] mem_store_data;
  logic        mem_flush;
  logic        mem2_allow_in;
  logic        dbus_req;
  logic        dbus_wr;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_wstrb;
  logic [31:0] dbus_wdata;
  logic        dbus_addr_ok;
  logic        dbus_data_ok;
  logic        mem2_data_ok;
  logic        mem_adel;
  logic        mem_ades;
  logic        mem_stall;
  logic        mem_req_done;

  always #5 clk = ~clk;

  mem_dbus_req #(.MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_load_type(mem_load_type), .mem_store_type(mem_store_type),
    .mem_addr(mem_addr), .mem_store_data(mem_store_data),
    .mem_flush(mem_flush), .mem2_allow_in(mem2_allow_in),
    .dbus_req(dbus_req), .dbus_wr(dbus_wr), .dbus_addr(dbus_addr),
    .dbus_wstrb(dbus_wstrb), .dbus_wdata(dbus_wdata),
    .dbus_addr_ok(dbus_addr_ok), .dbus_data_ok(dbus_data_ok),
    .mem2_data_ok(mem2_data_ok), .mem_adel(mem_adel), .mem_ades(mem_ades),
    .mem_stall(mem_stall), .mem_req_done(mem_req_done)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: where the current transaction is, plus response bookkeeping.
  typedef enum {NO_TXN, WAIT_ACCEPT, WAIT_MEM2, DROPPED} txn_phase_t;
  txn_phase_t  ph;
  int          outs, disc;
  logic        m_wr;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic        last_stall;

  task automatic model_reset();
    ph = NO_TXN; outs = 0; disc = 0; last_stall = 1'b0;
  endtask

  task automatic idle_inputs();
    mem_valid = 1'b0; mem_load_type = 3'd0; mem_store_type = 2'd0;
    mem_addr = 32'b0; mem_store_data = 32'b0; mem_flush = 1'b0;
    mem2_allow_in = 1'b0; dbus_addr_ok = 1'b0; dbus_data_ok = 1'b0;
  endtask

  task automatic set_op(input logic [2:0] lt, input logic [1:0] stt,
                        input logic [31:0] a, input logic [31:0] rt);
    mem_valid = 1'b1; mem_load_type = lt; mem_store_type = stt;
    mem_addr = a; mem_store_data = rt;
  endtask

  // Called #1 after the negedge with inputs stable: compare, advance model, move to next negedge.
  task automatic step();
    logic ld, st, mis, busy, done, go, discard, dec, exp_stall;
    int   sz;
    ld = mem_valid && (mem_load_type inside {[1:5]});
    st = mem_valid && !ld && (mem_store_type != 2'd0);
    if (ld) sz = (mem_load_type <= 3'd2) ? 1 : (mem_load_type <= 3'd4) ? 2 : 4;
    else    sz = (mem_store_type == 2'd1) ? 1 : (mem_store_type == 2'd2) ? 2 : 4;
    mis  = (ld || st) && ((mem_addr % sz) != 0);
    busy = (ph == WAIT_ACCEPT) || (ph == DROPPED);
    done = !mem_flush && mem2_allow_in &&
           ((ph == WAIT_ACCEPT && dbus_addr_ok) || ph == WAIT_MEM2);
    exp_stall = (ld || st) && !mis && !mem_flush && !done && (ph != DROPPED);

    check("adel", mem_adel, ld && mis);
    check("ades", mem_ades, st && mis);
    check("req", dbus_req, busy);
    check("stall", mem_stall, exp_stall);
    check("done", mem_req_done, done);
    check("m2ok", mem2_data_ok, dbus_data_ok && disc == 0);
    if (busy) begin
      check("wr", dbus_wr, m_wr);
      check("addr", dbus_addr, m_addr);
      check("wstrb", dbus_wstrb, m_wstrb);
      check("wdata", dbus_wdata, m_wdata);
    end

    go = (ld || st) && !mis && !mem_flush && ph == NO_TXN && outs < MAX_OUT;
    discard = 1'b0;
    case (ph)
      NO_TXN: if (go) begin
        ph = WAIT_ACCEPT;
        m_wr = st;
        m_addr = mem_addr;
        if (st) begin
          m_wstrb = 4'(((1 << sz) - 1) << (mem_addr % 4));
          if (sz == 1)      m_wdata = (mem_store_data & 32'hff) * 32'h01010101;
          else if (sz == 2) m_wdata = (mem_store_data & 32'hffff) * 32'h00010001;
          else              m_wdata = mem_store_data;
        end else begin
          m_wstrb = 4'b0000;
          m_wdata = 32'b0;
        end
      end
      WAIT_ACCEPT: begin
        if (dbus_addr_ok) begin
          if (mem_flush) begin discard = 1'b1; ph = NO_TXN; end
          else if (mem2_allow_in) ph = NO_TXN;
          else ph = WAIT_MEM2;
        end else if (mem_flush) ph = DROPPED;
      end
      WAIT_MEM2: begin
        if (mem_flush) begin discard = 1'b1; ph = NO_TXN; end
        else if (mem2_allow_in) ph = NO_TXN;
      end
      DROPPED: if (dbus_addr_ok) begin discard = 1'b1; ph = NO_TXN; end
      default: ;
    endcase
    dec  = dbus_data_ok && disc > 0;
    outs = outs + int'(busy && dbus_addr_ok) - int'(dbus_data_ok);
    disc = disc + int'(discard) - int'(dec);
    last_stall = exp_stall;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic new_instr();
    logic [31:0] a;
    a = $urandom;
    case ($urandom_range(0, 3))
      1: a[0] = 1'b0;
      2, 3: a[1:0] = 2'b00;
      default: ;
    endcase
    mem_valid = ($urandom_range(0, 6) != 0);
    case ($urandom_range(0, 2))
      0: begin mem_load_type = 3'($urandom_range(0, 7)); mem_store_type = 2'd0; end
      1: begin mem_load_type = 3'd0; mem_store_type = 2'($urandom_range(0, 3)); end
      default: begin
        mem_load_type = 3'($urandom_range(0, 7));
        mem_store_type = 2'($urandom_range(0, 3));
      end
    endcase
    mem_addr = a;
    mem_store_data = $urandom;
  endtask

  initial begin
    resetn = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", dbus_req, 1'b0);
    check("rst_wr", dbus_wr, 1'b0);
    check("rst_addr", dbus_addr, 32'b0);
    check("rst_wstrb", dbus_wstrb, 4'b0000);
    check("rst_wdata", dbus_wdata, 32'b0);
    check("rst_m2ok", mem2_data_ok, 1'b0);
    check("rst_done", mem_req_done, 1'b0);
    check("rst_stall", mem_stall, 1'b0);
    resetn = 1'b1;
    @(negedge clk);

    // SB to the top byte lane, accepted at once.
    set_op(3'd0, 2'd1, 32'h1003, 32'h0000_00A5); mem2_allow_in = 1'b1;
    #1; check("sb_stall_first", mem_stall, 1'b1); check("sb_no_req_yet", dbus_req, 1'b0); step();
    dbus_addr_ok = 1'b1;
    #1;
    check("sb_req", dbus_req, 1'b1); check("sb_wr", dbus_wr, 1'b1);
    check("sb_wstrb", dbus_wstrb, 4'b1000); check("sb_wdata", dbus_wdata, 32'hA5A5A5A5);
    check("sb_done", mem_req_done, 1'b1); check("sb_stall_second", mem_stall, 1'b0);
    step();
    idle_inputs(); dbus_data_ok = 1'b1;
    #1; check("sb_resp_live", mem2_data_ok, 1'b1); step();

    // Misaligned accesses raise exceptions and never request.
    idle_inputs(); set_op(3'd5, 2'd0, 32'h2002, 32'h0);
    #1; check("lw_adel", mem_adel, 1'b1); check("lw_adel_nostall", mem_stall, 1'b0); step();
    #1; check("lw_adel_noreq", dbus_req, 1'b0); step();
    set_op(3'd0, 2'd2, 32'h2001, 32'h1234_5678);
    #1; check("sh_ades", mem_ades, 1'b1); check("sh_no_adel", mem_adel, 1'b0); step();
    idle_inputs(); #1; step();

    // LW whose addr_ok arrives after three waiting cycles.
    set_op(3'd5, 2'd0, 32'h3000, 32'h0); mem2_allow_in = 1'b1;
    #1; step();
    for (int k = 0; k < 3; k++) begin
      #1; check("lw_wait_req", dbus_req, 1'b1); check("lw_wait_addr", dbus_addr, 32'h3000);
      check("lw_wait_stall", mem_stall, 1'b1); step();
    end
    dbus_addr_ok = 1'b1;
    #1; check("lw_late_done", mem_req_done, 1'b1); check("lw_late_wstrb", dbus_wstrb, 4'b0000); step();
    idle_inputs(); dbus_data_ok = 1'b1; #1; step();

    // Flush before addr_ok: the response of the cancelled LW is dropped.
    idle_inputs(); set_op(3'd5, 2'd0, 32'h4000, 32'h0); mem2_allow_in = 1'b1;
    #1; step();
    mem_flush = 1'b1; #1; check("flush_nostall", mem_stall, 1'b0); step();
    idle_inputs(); set_op(3'd5, 2'd0, 32'h4100, 32'h0);
    #1; check("cancel_req_held", dbus_req, 1'b1); check("cancel_nostall", mem_stall, 1'b0); step();
    dbus_addr_ok = 1'b1; #1; step();
    idle_inputs(); dbus_data_ok = 1'b1;
    #1; check("flushed_resp_dropped", mem2_data_ok, 1'b0); step();
    idle_inputs(); set_op(3'd5, 2'd0, 32'h4200, 32'h0); mem2_allow_in = 1'b1;
    #1; step();
    dbus_addr_ok = 1'b1; #1; step();
    idle_inputs(); dbus_data_ok = 1'b1;
    #1; check("next_resp_live", mem2_data_ok, 1'b1); step();

    // Outstanding limit: third LW waits for a data_ok.
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      set_op(3'd5, 2'd0, 32'h5000 + 32'(4 * i), 32'h0); mem2_allow_in = 1'b1; dbus_addr_ok = 1'b0;
      #1; step();
      dbus_addr_ok = 1'b1; #1; step();
    end
    set_op(3'd5, 2'd0, 32'h5100, 32'h0); dbus_addr_ok = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1; check("limit_no_req", dbus_req, 1'b0); check("limit_stall", mem_stall, 1'b1); step();
    end
    dbus_data_ok = 1'b1; #1; check("limit_stall_dok", mem_stall, 1'b1); step();
    dbus_data_ok = 1'b0; #1; step();
    dbus_addr_ok = 1'b1;
    #1; check("limit_req_issued", dbus_req, 1'b1); check("limit_done", mem_req_done, 1'b1); step();
    idle_inputs(); dbus_data_ok = 1'b1; #1; step(); #1; step();
    dbus_data_ok = 1'b0;

    // MEM2 busy after acceptance: HOLD, then release.
    set_op(3'd5, 2'd0, 32'h6000, 32'h0); mem2_allow_in = 1'b0;
    #1; step();
    dbus_addr_ok = 1'b1; #1; step();
    dbus_addr_ok = 1'b0;
    #1; check("hold_stall", mem_stall, 1'b1); check("hold_no_req", dbus_req, 1'b0); step();
    mem2_allow_in = 1'b1;
    #1; check("hold_done", mem_req_done, 1'b1); check("hold_release", mem_stall, 1'b0); step();
    idle_inputs(); dbus_data_ok = 1'b1; #1; step();

    // Reset in the middle of a request.
    idle_inputs(); set_op(3'd0, 2'd3, 32'h7000, 32'hDEAD_BEEF); mem2_allow_in = 1'b1;
    #1; step();
    resetn = 1'b0;
    #1;
    check("midrst_req", dbus_req, 1'b0); check("midrst_wstrb", dbus_wstrb, 4'b0000);
    check("midrst_wdata", dbus_wdata, 32'b0); check("midrst_addr", dbus_addr, 32'b0);
    model_reset(); idle_inputs();
    @(negedge clk);
    resetn = 1'b1;
    #1; step();

    // Randomized pipeline traffic.
    new_instr();
    for (int c = 0; c < 4000; c++) begin
      if (!last_stall) new_instr();
      mem_flush     = ($urandom_range(0, 19) == 0);
      mem2_allow_in = ($urandom_range(0, 3) != 0);
      dbus_addr_ok  = ($urandom_range(0, 1) == 1);
      dbus_data_ok  = (outs > 0) && ($urandom_range(0, 2) == 0);
      #1; step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
